mc_datapath: RTL
================

// Module: mc_datapath
// PURPOSE
// - Parametrised multi-cycle RV32I datapath; successor to the single-cycle datapath. Control inputs are driven by an external decoder.
// - Adds a 5-phase sequencer, stage registers (IR/A/B/ALUOUT/MDR) and one shared valid/ready memory port for fetch and data.
// - Sits between the control decoder and a unified instruction/data memory.
// PARAMETERS
// - NREGS     32            number of architectural registers; 16 (RV32E) or 32
// - RESET_PC  32'h0000_0000 PC value loaded at reset
// PORTS
// - clk        in   1   clock, rising edge
// - rst        in   1   asynchronous, active-low reset
// - pc_sel     in   1   0: PC+4, 1: ALUOUT with bits[1:0] forced to 0
// - imm_sel    in   3   0:I 1:S 2:B 3:U 4:J; 5-7 give imm=0
// - reg_wen    in   1   write rd in WB
// - br_un      in   1   unsigned branch compare
// - a_sel      in   1   ALU A operand: 0 = A reg, 1 = PC
// - b_sel      in   1   ALU B operand: 0 = B reg, 1 = imm
// - alu_ctrl   in   4   ALU op (see BEHAVIOUR)
// - mem_rd     in   1   instruction performs a load
// - mem_wr     in   1   instruction performs a store
// - wb_sel     in   2   0: MDR, 1: ALUOUT, 2: PC+4, 3: ALUOUT
// - inst       out  32  IR contents
// - inst_valid out  1   high in DECODE..WB; control inputs are valid only while it is high
// - br_eq      out  1   A==B; registered in DECODE
// - br_lt      out  1   A<B, signed or unsigned per br_un; registered in DECODE
// - mem_req    out  1   memory request
// - mem_we     out  1   write request; 0 for fetch and load
// - mem_addr   out  32  byte address, word aligned
// - mem_wdata  out  32  store data (B register)
// - mem_ready  in   1   transfer completes in any cycle where mem_req & mem_ready
// - mem_rdata  in   32  read data; valid when mem_ready is high
// BEHAVIOUR
// - FSM states: FETCH -> DECODE -> EXEC -> (MEM if mem_rd|mem_wr) -> WB -> FETCH.
// - FETCH: mem_req=1, mem_we=0, mem_addr=PC until mem_ready. IR<=mem_rdata. Minimum 1 cycle.
// - DECODE: A<=RF[rs1] and B<=RF[rs2]; br_eq and br_lt registered.
// - EXEC: ALUOUT<=alu(opA,opB).
// - MEM: mem_addr=ALUOUT, mem_we=mem_wr, mem_wdata=B. Request held until mem_ready. MDR<=mem_rdata on a load.
// - WB: if reg_wen, RF[rd]<=wb mux value. PC<=pc_next.
// - Latency: ALU instruction = 4 cycles plus fetch wait; load/store = 5 cycles plus both waits.
// - Request rules: while mem_req=1, address, data and mem_we stay stable. No new request is issued in the cycle a transfer completes.
// - alu_ctrl codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1111 PASS_B; others give 0.
// - Shifts use opB[4:0]. Arithmetic wraps modulo 2^32. SLT/SLTU return 0 or 1.
// - x0 reads 0; writes to x0 are dropped.
// - NREGS=16: a register index >=16 reads 0, and a write to it is dropped.
// - rs1==rd: the read in DECODE returns the old value; the write lands in WB.
// - Reset (async, any state): state=FETCH, PC=RESET_PC, all RF/IR/A/B/ALUOUT/MDR=0, every output=0.
//   mem_req falls immediately; an in-flight transfer is abandoned.
// - Reset release: the first fetch begins on the first clk edge with rst=1.
// - Misaligned data addresses are passed through unmodified; no trap is raised.
// CONFIGURATION
// - PERF_CNT_EN defined: adds two 64-bit outputs, cycle_cnt and instret_cnt. Both reset to 0 and wrap at 2^64.
//   - cycle_cnt: +1 every clk edge.
//   - instret_cnt: +1 on each exit from WB.
// - PERF_CNT_EN undefined: the ports and logic are absent; all other behaviour is identical.
// TESTING
// - Reset mid-MEM with mem_req=1 -> mem_req=0 immediately; after release mem_addr=RESET_PC, state FETCH.
// - addi x1,x0,5 with mem_ready always 1 -> x1=5 after 4 cycles; PC=RESET_PC+4.
// - add x2,x1,x1 after x1=5, then write x0 -> x2=10 and x0 reads 0.
// - sw x2,8(x0) with ready delayed 3 cycles -> mem_addr=8, mem_we=1, mem_wdata=10 held for 4 cycles.
// - lw x3,8(x0) with mem_rdata=10 -> x3=10.
// - beq x1,x1,-8 with br_eq=1 and pc_sel=1 -> PC=old PC-8.
// - NREGS=16, write to x20 -> no write; a read of x20 returns 0.
// - PERF_CNT_EN: 3 ALU instructions with zero-wait memory -> instret_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/mc_datapath.sv
// mc_datapath -- multi-cycle RV32I datapath driven by an external control decoder.
//
// A five-phase sequencer (FETCH, DECODE, EXEC, optional MEM, WB) steps each
// instruction through the stage registers IR, A, B, ALUOUT and MDR. A single
// valid/ready memory port is shared between instruction fetch and data access.
//
// Parameters
//   NREGS     number of architectural registers, 16 (RV32E) or 32
//   RESET_PC  PC value loaded by reset
//
// Ports
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   pc_sel, imm_sel, reg_wen,  control inputs from the decoder; they are only
//   br_un, a_sel, b_sel,       sampled while inst_valid is high
//   alu_ctrl, mem_rd, mem_wr,
//   wb_sel
//   inst, inst_valid           IR contents and DECODE..WB marker
//   br_eq, br_lt               rs1/rs2 compare results captured in DECODE
//   mem_req, mem_we, mem_addr, shared memory port; a transfer completes in any
//   mem_wdata, mem_ready,      cycle where mem_req and mem_ready are both high
//   mem_rdata
//
// Optional feature macro: PERF_CNT_EN adds the 64-bit cycle_cnt and
// instret_cnt outputs. Without it those ports and counters do not exist.
module mc_datapath #(
  parameter int unsigned NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_sel,
  input  logic [2:0]  imm_sel,
  input  logic        reg_wen,
  input  logic        br_un,
  input  logic        a_sel,
  input  logic        b_sel,
  input  logic [3:0]  alu_ctrl,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  wb_sel,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        br_eq,
  output logic        br_lt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        mem_req_q, mem_we_q, inst_valid_q, br_eq_q, br_lt_q;
  logic [31:0] rf_q [NREGS];

  logic        rs1_ok_s, rs2_ok_s, rd_ok_s;
  logic [31:0] rs1_s, rs2_s, imm_s, op_a_s, op_b_s;
  logic [31:0] alu_d, pc_d, wb_d, pc_plus4_s;
  logic        unused_opcode_s;

  function automatic logic [31:0] imm_gen(input logic [2:0] sel, input logic [31:0] ir);
    logic [31:0] r;
    r = 32'd0;
    case (sel)
      3'd0:    r = {{20{ir[31]}}, ir[31:20]};
      3'd1:    r = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      3'd2:    r = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      3'd3:    r = {ir[31:12], 12'd0};
      3'd4:    r = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << b[4:0];
      4'b0010: r = {31'd0, $signed(a) < $signed(b)};
      4'b0011: r = {31'd0, a < b};
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b1101: r = $signed(a) >>> b[4:0];
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1111: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // x0 and indices beyond the implemented file read as zero and are never written.
  assign rs1_ok_s = (ir_q[19:15] != 5'd0) && (32'(ir_q[19:15]) < NREGS);
  assign rs2_ok_s = (ir_q[24:20] != 5'd0) && (32'(ir_q[24:20]) < NREGS);
  assign rd_ok_s  = (ir_q[11:7]  != 5'd0) && (32'(ir_q[11:7])  < NREGS);
  assign rs1_s    = rs1_ok_s ? rf_q[ir_q[15 +: AW]] : 32'd0;
  assign rs2_s    = rs2_ok_s ? rf_q[ir_q[20 +: AW]] : 32'd0;

  assign imm_s      = imm_gen(imm_sel, ir_q);
  assign op_a_s     = a_sel ? pc_q : a_q;
  assign op_b_s     = b_sel ? imm_s : b_q;
  assign alu_d      = alu_f(alu_ctrl, op_a_s, op_b_s);
  assign pc_plus4_s = pc_q + 32'd4;
  assign pc_d       = pc_sel ? {alu_q[31:2], 2'b00} : pc_plus4_s;
  assign wb_d       = (wb_sel == 2'd0) ? mdr_q : ((wb_sel == 2'd2) ? pc_plus4_s : alu_q);

  // The opcode field is decoded outside this block.
  assign unused_opcode_s = ^ir_q[6:0];

  // Sequencer, stage registers and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= 32'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      alu_q        <= 32'd0;
      mdr_q        <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      inst_valid_q <= 1'b0;
      br_eq_q      <= 1'b0;
      br_lt_q      <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_req_q && mem_ready) begin
            ir_q         <= mem_rdata;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b1;
            state_q      <= S_DECODE;
          end else if (!mem_req_q) begin
            // Only reached straight after reset: WB normally raises the fetch request.
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end
        end
        S_DECODE: begin
          a_q     <= rs1_s;
          b_q     <= rs2_s;
          br_eq_q <= (rs1_s == rs2_s);
          br_lt_q <= br_un ? (rs1_s < rs2_s) : ($signed(rs1_s) < $signed(rs2_s));
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          alu_q <= alu_d;
          if (mem_rd || mem_wr) begin
            // Data address is forwarded unaligned; alignment is the decoder's concern.
            mem_req_q   <= 1'b1;
            mem_we_q    <= mem_wr;
            mem_addr_q  <= alu_d;
            mem_wdata_q <= b_q;
            state_q     <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (mem_rd) begin
              mdr_q <= mem_rdata;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_WB;
          end
        end
        S_WB: begin
          pc_q         <= pc_d;
          mem_req_q    <= 1'b1;
          mem_we_q     <= 1'b0;
          mem_addr_q   <= pc_d;
          inst_valid_q <= 1'b0;
          state_q      <= S_FETCH;
        end
        default: begin
          mem_req_q    <= 1'b0;
          mem_we_q     <= 1'b0;
          inst_valid_q <= 1'b0;
          state_q      <= S_FETCH;
        end
      endcase
    end
  end

  // Register file: cleared by reset, written only in WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if ((state_q == S_WB) && reg_wen && rd_ok_s) begin
      rf_q[ir_q[7 +: AW]] <= wb_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [63:0] cycle_q, instret_q;

  // Free-running cycle counter and retired-instruction counter (one per WB exit).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (state_q == S_WB) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

  assign inst       = ir_q;
  assign inst_valid = inst_valid_q;
  assign br_eq      = br_eq_q;
  assign br_lt      = br_lt_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
